matmul_axil_slave: RTL and testbench
====================================

// Module: matmul_axil_slave
// PURPOSE
//  AXI4-Lite slave for the multiplication IP, driven by the AXI4-Lite master BFM in the bd test.
//  Holds four R/W registers (A, B, CTRL, SCRATCH) and four read-only result registers.
//  A sequential MAC engine computes C = A x B on 2x2 matrices of unsigned 8-bit elements.
//  Registers 0x00-0x0C read back exactly what was written, as the BFM write/read-compare test requires.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 is supported.
//  C_S_AXI_ADDR_WIDTH  6   Byte address width; decode uses ADDR[5:2].
//  ELEM_WIDTH          8   Matrix element width; four elements packed per 32-bit word.
// PORTS
//  S_AXI_ACLK     in   1   Clock.
//  S_AXI_ARESET   in   1   Asynchronous reset, active-high.
//  S_AXI_AWADDR   in   6   Write address.        S_AXI_AWPROT  in 3   Ignored.
//  S_AXI_AWVALID  in   1   Write address valid.  S_AXI_AWREADY out 1  Write address ready.
//  S_AXI_WDATA    in   32  Write data.           S_AXI_WSTRB   in 4   Byte enables.
//  S_AXI_WVALID   in   1   Write data valid.     S_AXI_WREADY  out 1  Write data ready.
//  S_AXI_BRESP    out  2   Always 2'b00 (OKAY).  S_AXI_BVALID  out 1  Write response valid.
//  S_AXI_BREADY   in   1   Write response ready.
//  S_AXI_ARADDR   in   6   Read address.         S_AXI_ARPROT  in 3   Ignored.
//  S_AXI_ARVALID  in   1   Read address valid.   S_AXI_ARREADY out 1  Read address ready.
//  S_AXI_RDATA    out  32  Read data.            S_AXI_RRESP   out 2  Always 2'b00 (OKAY).
//  S_AXI_RVALID   out  1   Read data valid.      S_AXI_RREADY  in  1  Read data ready.
//  busy_o         out  1   Engine running.       done_o        out 1  Sticky completion flag.
// BEHAVIOUR
//  Reset: every ready/valid output = 0, RDATA = 0, all registers = 0, FSM = IDLE, busy_o = 0, done_o = 0.
//  Register map:
//   0x00 A (R/W): a00 = [7:0], a01 = [15:8], a10 = [23:16], a11 = [31:24].
//   0x04 B (R/W): same packing as A.
//   0x08 CTRL (R/W, full 32-bit readback): bit0 = start.
//   0x0C SCRATCH (R/W).
//   0x10 C00, 0x14 C01, 0x18 C10, 0x1C C11 (RO): zero-extended 17-bit sums.
//   0x20 STATUS (RO): bit0 = busy, bit1 = done.
//   Other addresses read 0.
//  Writes to RO or unmapped addresses are discarded but still answered with OKAY; WSTRB masks bytes.
//  Write channel:
//   - AW and W are accepted independently; each ready pulses for 1 cycle on its handshake.
//   - The register update and BVALID both occur on the edge after both handshakes have completed.
//   - BVALID is held until BREADY; no new AW or W is accepted while BVALID = 1.
//  Read channel:
//   - ARREADY pulses 1 cycle; RVALID/RDATA are registered on the next edge.
//   - RVALID is held until RREADY; ARREADY = 0 while RVALID = 1.
//  Read and write may complete in the same cycle; a read of a register being written returns the old value.
//  FSM IDLE/MAC/DONE:
//   - A committed CTRL write with bit0 = 1 while in IDLE snapshots A and B, clears done, and enters MAC.
//   - MAC runs 8 cycles, one multiply-accumulate (8x8 -> 16-bit product, 17-bit accumulator) per cycle,
//     order C00, C01, C10, C11, two terms each. Result values are held internally during MAC.
//   - DONE (1 cycle) copies all four results into C00-C11 atomically, sets done, then returns to IDLE.
//   - Result registers change only in DONE; reads during MAC return the previous results.
//   - A start written while not in IDLE is ignored; the CTRL register still updates.
//   - Writes to A/B during MAC do not affect the running computation.
//   - Start-to-done latency: done = 1 exactly 9 cycles after the committing edge.
//   - Reset mid-operation aborts the computation and clears results and done.
// TESTING
//  1. Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00-0x0C, reading each back -> exact match, RESP = OKAY.
//  2. Scenario 1, then poll 0x20 until done -> C00 = 0xCD32, C01 = 0xAA55, C10 = 0xCE, C11 = 0xAB.
//  3. A = B = 0xFFFFFFFF, start -> each Cij = 0x1FC02 (17-bit max); no overflow.
//  4. Start again while busy -> CTRL reads back the new value; done still asserts 9 cycles after the first start.
//  5. AW first, W 3 cycles later, BREADY held low 2 cycles -> single update, BVALID held, AWREADY = 0 meanwhile.
//  6. Assert S_AXI_ARESET during MAC -> all outputs and registers = 0; 0x20 reads 0 after release.

Source files
------------

// File: rtl/matmul_axil_slave_if.sv
// AXI4-Lite bus bundle for the 2x2 matrix-multiply slave.
// The master modport drives requests; the slave modport drives readies and responses.
interface matmul_axil_slave_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/matmul_axil_slave.sv
// AXI4-Lite slave with A/B/CTRL/SCRATCH registers and a sequential MAC engine
// computing C = A x B for 2x2 matrices of unsigned elements.
module matmul_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned ELEM_WIDTH         = 8
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  matmul_axil_slave_if.slave   s_axi,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned ProdW = 2 * ELEM_WIDTH;
  localparam int unsigned AccW  = ProdW + 1;

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  // Bus channel state
  logic                 awready_q, wready_q, bvalid_q;
  logic                 arready_q, rvalid_q;
  logic [DW-1:0]        rdata_q;
  logic                 aw_done_q, w_done_q;
  logic [3:0]           wr_idx_q;
  logic [DW-1:0]        wdata_q;
  logic [DW/8-1:0]      wstrb_q;

  // Register file
  logic [DW-1:0]        reg_a_q, reg_b_q, reg_ctrl_q, reg_scratch_q;

  // Engine state
  state_e                         state_q;
  logic [2:0]                     cnt_q;
  logic [3:0][ELEM_WIDTH-1:0]     snap_a_q, snap_b_q;
  logic [3:0][AccW-1:0]           acc_q, res_q;
  logic                           busy_q, done_q;

  // Combinational helpers
  logic                 aw_hs, w_hs, ar_hs, wr_commit, start;
  logic [DW-1:0]        wr_old, wmask, wr_merged, rd_mux;
  logic [3:0]           rd_idx;
  logic [ELEM_WIDTH-1:0] mac_a, mac_b;
  logic [ProdW-1:0]     prod;

  assign aw_hs     = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs      = s_axi.S_AXI_WVALID & wready_q;
  assign ar_hs     = s_axi.S_AXI_ARVALID & arready_q;
  // Both halves of the write are latched; commit on the following edge.
  assign wr_commit = aw_done_q & w_done_q;
  assign rd_idx    = s_axi.S_AXI_ARADDR[5:2];

  always_comb begin
    wr_old = '0;
    case (wr_idx_q)
      4'h0:    wr_old = reg_a_q;
      4'h1:    wr_old = reg_b_q;
      4'h2:    wr_old = reg_ctrl_q;
      4'h3:    wr_old = reg_scratch_q;
      default: wr_old = '0;
    endcase
    wmask = '0;
    for (int i = 0; i < DW / 8; i++) begin
      wmask[8*i +: 8] = {8{wstrb_q[i]}};
    end
    wr_merged = (wr_old & ~wmask) | (wdata_q & wmask);
  end

  assign start = wr_commit && (wr_idx_q == 4'h2) && wr_merged[0] && (state_q == StIdle);

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      4'h0:    rd_mux = reg_a_q;
      4'h1:    rd_mux = reg_b_q;
      4'h2:    rd_mux = reg_ctrl_q;
      4'h3:    rd_mux = reg_scratch_q;
      4'h4:    rd_mux = DW'(res_q[0]);
      4'h5:    rd_mux = DW'(res_q[1]);
      4'h6:    rd_mux = DW'(res_q[2]);
      4'h7:    rd_mux = DW'(res_q[3]);
      4'h8:    rd_mux = {{(DW-2){1'b0}}, done_q, busy_q};
      default: rd_mux = '0;
    endcase
  end

  // Write channel and register file
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      wr_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      reg_a_q       <= '0;
      reg_b_q       <= '0;
      reg_ctrl_q    <= '0;
      reg_scratch_q <= '0;
    end else begin
      awready_q <= ~awready_q & s_axi.S_AXI_AWVALID & ~aw_done_q & ~bvalid_q;
      wready_q  <= ~wready_q & s_axi.S_AXI_WVALID & ~w_done_q & ~bvalid_q;
      if (aw_hs) begin
        aw_done_q <= 1'b1;
        wr_idx_q  <= s_axi.S_AXI_AWADDR[5:2];
      end
      if (w_hs) begin
        w_done_q <= 1'b1;
        wdata_q  <= s_axi.S_AXI_WDATA;
        wstrb_q  <= s_axi.S_AXI_WSTRB;
      end
      if (wr_commit) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        case (wr_idx_q)
          4'h0:    reg_a_q       <= wr_merged;
          4'h1:    reg_b_q       <= wr_merged;
          4'h2:    reg_ctrl_q    <= wr_merged;
          4'h3:    reg_scratch_q <= wr_merged;
          default: ;
        endcase
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel; data is sampled at the handshake edge, so a same-cycle write is not visible.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= ~arready_q & s_axi.S_AXI_ARVALID & ~rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // cnt_q = {i, j, k}: result element {i,j}, term k -> a[i][k] * b[k][j]
  always_comb begin
    mac_a = snap_a_q[{cnt_q[2], cnt_q[0]}];
    mac_b = snap_b_q[{cnt_q[0], cnt_q[1]}];
    prod  = {{ELEM_WIDTH{1'b0}}, mac_a} * {{ELEM_WIDTH{1'b0}}, mac_b};
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      snap_a_q <= '0;
      snap_b_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            snap_a_q <= reg_a_q;
            snap_b_q <= reg_b_q;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StMac;
          end
        end
        StMac: begin
          acc_q[cnt_q[2:1]] <= (cnt_q[0] ? acc_q[cnt_q[2:1]] : '0) + {1'b0, prod};
          cnt_q             <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          res_q   <= acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign busy_o              = busy_q;
  assign done_o              = done_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_matmul_axil_slave.sv
// Directed + randomized bench for matmul_axil_slave with an arithmetic reference model.
module tb_matmul_axil_slave;

  logic tb_ACLK = 1'b0;
  logic tb_ARESET = 1'b1;
  logic busy, done;
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0, n_fail = 0;
  int   commit_cyc = 0;

  always #5 tb_ACLK = ~tb_ACLK;
  always @(posedge tb_ACLK) cyc <= cyc + 1;

  matmul_axil_slave_if axi ();

  matmul_axil_slave dut (
    .S_AXI_ACLK   (tb_ACLK),
    .S_AXI_ARESET (tb_ARESET),
    .s_axi        (axi.slave),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Reference model state
  logic [31:0] mdl_regs [4];
  logic [31:0] mdl_res  [4];
  logic [31:0] mdl_pend [4];
  bit          mdl_busy, mdl_done;

  function automatic logic [31:0] mm(input logic [31:0] a, input logic [31:0] b,
                                     input int i, input int j);
    int s = 0;
    for (int k = 0; k < 2; k++) begin
      s += int'(a[8*(2*i+k) +: 8]) * int'(b[8*(2*k+j) +: 8]);
    end
    return 32'(s);
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 4; i++) begin
      mdl_regs[i] = '0;
      mdl_res[i]  = '0;
      mdl_pend[i] = '0;
    end
    mdl_busy = 0;
    mdl_done = 0;
  endfunction

  function automatic void mdl_write(input logic [5:0] addr, input logic [31:0] d,
                                    input logic [3:0] s);
    int idx = int'(addr[5:2]);
    logic [31:0] m, nv;
    if (idx > 3) return;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    nv = (mdl_regs[idx] & ~m) | (d & m);
    mdl_regs[idx] = nv;
    if (idx == 2 && nv[0] && !mdl_busy) begin
      mdl_busy = 1;
      mdl_done = 0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) mdl_pend[2*i+j] = mm(mdl_regs[0], mdl_regs[1], i, j);
    end
  endfunction

  function automatic void mdl_complete();
    for (int i = 0; i < 4; i++) mdl_res[i] = mdl_pend[i];
    mdl_busy = 0;
    mdl_done = 1;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [5:0] addr);
    int idx = int'(addr[5:2]);
    if (idx < 4) return mdl_regs[idx];
    if (idx < 8) return mdl_res[idx-4];
    if (idx == 8) return {30'd0, mdl_done, mdl_busy};
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_delay, input int b_hold);
    bit aw_pend = 1, w_pend = 1, aw_hs, w_hs;
    int n = 0;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_WVALID  = (w_delay == 0);
    axi.S_AXI_BREADY  = (b_hold == 0);
    while ((aw_pend || w_pend) && n < 40) begin
      aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge tb_ACLK); #1;
      n++;
      if (aw_hs) begin axi.S_AXI_AWVALID = 1'b0; aw_pend = 0; end
      if (w_hs)  begin axi.S_AXI_WVALID = 1'b0; w_pend = 0; end
      if (!aw_pend && w_pend) begin
        check("awready_while_w_pending", axi.S_AXI_AWREADY, 0);
        check("bvalid_before_w", axi.S_AXI_BVALID, 0);
      end
      if (w_pend && !w_hs && n >= w_delay) axi.S_AXI_WVALID = 1'b1;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    n = 0;
    while (!axi.S_AXI_BVALID && n < 40) begin
      @(posedge tb_ACLK); #1;
      n++;
    end
    check("bvalid_arrives", axi.S_AXI_BVALID, 1);
    check("bresp_okay", axi.S_AXI_BRESP, 0);
    commit_cyc = cyc;
    for (int h = 0; h < b_hold; h++) begin
      @(posedge tb_ACLK); #1;
      check("bvalid_held", axi.S_AXI_BVALID, 1);
      check("awready_blocked", axi.S_AXI_AWREADY, 0);
    end
    axi.S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    axi.S_AXI_BREADY = 1'b0;
    check("bvalid_clears", axi.S_AXI_BVALID, 0);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    bit hs = 0;
    int n = 0;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b1;
    while (!hs && n < 40) begin
      hs = axi.S_AXI_ARREADY;
      @(posedge tb_ACLK); #1;
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    check("rvalid_after_ar", axi.S_AXI_RVALID, 1);
    check("rresp_okay", axi.S_AXI_RRESP, 0);
    data = axi.S_AXI_RDATA;
    @(posedge tb_ACLK); #1;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    mdl_write(addr, data, strb);
    axi_write(addr, data, strb, 0, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] addr);
    logic [31:0] d;
    axi_read(addr, d);
    check(tag, d, mdl_read(addr));
  endtask

  // Waits on done_o, checks start-to-done latency, then retires the model computation
  task automatic wait_done(input string tag, input int start_cyc);
    int n = 0;
    while (!done && n < 60) begin
      @(posedge tb_ACLK); #1;
      n++;
    end
    check(tag, 32'(cyc - start_cyc), 32'd9);
    mdl_complete();
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 4; i++) rd_chk(tag, 6'(16 + 4 * i));
    rd_chk({tag, "_status"}, 6'h20);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, axi.S_AXI_AWREADY, 0);
    check({tag, "_wready"}, axi.S_AXI_WREADY, 0);
    check({tag, "_bvalid"}, axi.S_AXI_BVALID, 0);
    check({tag, "_arready"}, axi.S_AXI_ARREADY, 0);
    check({tag, "_rvalid"}, axi.S_AXI_RVALID, 0);
    check({tag, "_rdata"}, axi.S_AXI_RDATA, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [31:0] d, a, b;
    int start_cyc, n;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0;  axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    mdl_reset();

    // Reset state
    repeat (3) @(posedge tb_ACLK);
    #1;
    check_idle_outputs("in_reset");
    tb_ARESET = 1'b0;
    @(posedge tb_ACLK); #1;
    check_idle_outputs("after_reset");
    for (int i = 0; i <= 9; i++) rd_chk("reset_reg", 6'(4 * i));

    // Register write/read-back; the CTRL value has bit0 set and launches the engine
    wr(6'h00, 32'h0101FFFF, 4'hF); rd_chk("rb_a", 6'h00);
    wr(6'h04, 32'hABCD0001, 4'hF); rd_chk("rb_b", 6'h04);
    wr(6'h08, 32'hDEAD0011, 4'hF);
    rd_chk("c00_old_during_mac", 6'h10);
    rd_chk("rb_ctrl", 6'h08);
    wr(6'h0C, 32'hBEEF0011, 4'hF); rd_chk("rb_scratch", 6'h0C);

    // Poll STATUS until done
    n = 0;
    d = '0;
    while (!d[1] && n < 20) begin
      axi_read(6'h20, d);
      n++;
    end
    check("status_poll_done", {31'd0, d[1]}, 1);
    mdl_complete();
    check("c00_known", mdl_res[0], 32'hCD32);
    check_results("scenario1");

    // Saturating operands: 17-bit sum without overflow
    wr(6'h00, 32'hFFFFFFFF, 4'hF);
    wr(6'h04, 32'hFFFFFFFF, 4'hF);
    wr(6'h08, 32'h00000001, 4'hF);
    wait_done("latency_max", commit_cyc);
    check("c11_max_model", mdl_res[3], 32'h1FC02);
    check_results("max");

    // Restart while busy is ignored; A changes during MAC do not reach the result
    wr(6'h00, $urandom, 4'hF);
    wr(6'h04, $urandom, 4'hF);
    wr(6'h08, 32'h00000001, 4'hF);
    start_cyc = commit_cyc;
    wr(6'h08, 32'h5A5A0001, 4'hF);
    wr(6'h00, $urandom, 4'hF);
    wait_done("latency_restart_ignored", start_cyc);
    repeat (12) @(posedge tb_ACLK);
    #1;
    check("busy_stays_low", busy, 0);
    check("done_sticky", done, 1);
    rd_chk("rb_ctrl_new", 6'h08);
    check_results("snapshot");

    // AW first, W three cycles later, B held off for two cycles
    d = $urandom;
    mdl_write(6'h0C, d, 4'hF);
    axi_write(6'h0C, d, 4'hF, 3, 2);
    rd_chk("rb_scratch_slow", 6'h0C);

    // Randomized matrices with partial strobes
    for (int it = 0; it < 5; it++) begin
      a = $urandom;
      b = $urandom;
      wr(6'h00, a, 4'($urandom_range(1, 15)));
      wr(6'h04, b, 4'hF);
      rd_chk("rand_a", 6'h00);
      wr(6'h08, $urandom | 32'd1, 4'hF);
      wait_done("rand_latency", commit_cyc);
      check_results("rand");
      wr(6'h0C, $urandom, 4'($urandom_range(0, 15)));
      rd_chk("rand_scratch", 6'h0C);
      wr(6'h10, $urandom, 4'hF);
      rd_chk("ro_discard", 6'h10);
      wr(6'h30, $urandom, 4'hF);
      rd_chk("unmapped", 6'h30);
      rd_chk("unmapped_24", 6'h24);
    end

    // Reset in the middle of MAC
    wr(6'h00, 32'hFFFFFFFF, 4'hF);
    wr(6'h08, 32'h00000001, 4'hF);
    repeat (3) @(posedge tb_ACLK);
    #2;
    tb_ARESET = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(posedge tb_ACLK);
    #1;
    tb_ARESET = 1'b0;
    mdl_reset();
    @(posedge tb_ACLK); #1;
    for (int i = 0; i <= 8; i++) rd_chk("post_reset_reg", 6'(4 * i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
